// File: rtl/user_obi_addr_demux.sv
// OBI address decoder / demultiplexer: routes one manager port to NumRules subordinates
// by address rule, answers unmapped accesses internally and keeps responses in order.
module user_obi_addr_demux #(
  parameter int unsigned NumRules       = 1,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 1,
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [NumRules-1:0][AddrWidth-1:0] RuleStart = {32'h2000_0000},
  parameter logic [NumRules-1:0][AddrWidth-1:0] RuleEnd   = {32'h2000_1000},
  parameter logic [DataWidth-1:0] ErrRdata = 32'hBADC_AB1E
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // manager side
  input  logic                          mgr_req_i,
  output logic                          mgr_gnt_o,
  input  logic [AddrWidth-1:0]          mgr_addr_i,
  input  logic                          mgr_we_i,
  input  logic [DataWidth/8-1:0]        mgr_be_i,
  input  logic [DataWidth-1:0]          mgr_wdata_i,
  input  logic [IdWidth-1:0]            mgr_aid_i,
  output logic                          mgr_rvalid_o,
  output logic [DataWidth-1:0]          mgr_rdata_o,
  output logic                          mgr_err_o,
  output logic [IdWidth-1:0]            mgr_rid_o,
  // subordinate side
  output logic [NumRules-1:0]           sbr_req_o,
  input  logic [NumRules-1:0]           sbr_gnt_i,
  output logic [AddrWidth-1:0]          sbr_addr_o,
  output logic                          sbr_we_o,
  output logic [DataWidth/8-1:0]        sbr_be_o,
  output logic [DataWidth-1:0]          sbr_wdata_o,
  output logic [IdWidth-1:0]            sbr_aid_o,
  input  logic [NumRules-1:0]           sbr_rvalid_i,
  input  logic [NumRules*DataWidth-1:0] sbr_rdata_i,
  input  logic [NumRules-1:0]           sbr_err_i,
  input  logic [NumRules*IdWidth-1:0]   sbr_rid_i,
  // status
  output logic                          busy_o,
  output logic                          unmapped_o
);

  localparam int unsigned SelWidth = $clog2(NumRules + 1);
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [SelWidth-1:0] ErrSel = SelWidth'(NumRules);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  logic [CntWidth-1:0] r_cnt;
  logic [SelWidth-1:0] r_last_sel;
  logic                r_err_valid;
  logic [IdWidth-1:0]  r_err_rid;

  logic [SelWidth-1:0] w_target;
  logic                w_hit;
  logic                w_is_err;
  logic                w_allow;
  logic                w_tgt_gnt;
  logic                w_hs;
  logic                w_sel_rvalid;
  logic                w_resp;

  // Address decode: lowest-index matching rule wins, otherwise the error subordinate.
  always_comb begin
    w_target = ErrSel;
    w_hit    = 1'b0;
    for (int unsigned i = 0; i < NumRules; i++) begin
      if (!w_hit && (mgr_addr_i >= RuleStart[i]) && (mgr_addr_i < RuleEnd[i])) begin
        w_hit    = 1'b1;
        w_target = SelWidth'(i);
      end
    end
  end

  assign w_is_err = (w_target == ErrSel);

  // A new request may only go to the subordinate that already owns the outstanding ones.
  assign w_allow = rst_ni && (r_cnt < CntMax) &&
                   ((r_cnt == '0) || (w_target == r_last_sel));

  always_comb begin
    sbr_req_o = '0;
    w_tgt_gnt = w_is_err;
    for (int unsigned i = 0; i < NumRules; i++) begin
      if (w_target == SelWidth'(i)) begin
        sbr_req_o[i] = w_allow & mgr_req_i;
        w_tgt_gnt    = sbr_gnt_i[i];
      end
    end
  end

  assign mgr_gnt_o = w_allow & w_tgt_gnt;
  assign w_hs      = mgr_req_i & mgr_gnt_o;

  // Response mux follows the subordinate of the outstanding transactions.
  always_comb begin
    w_sel_rvalid = 1'b0;
    mgr_rdata_o  = '0;
    mgr_err_o    = 1'b0;
    mgr_rid_o    = '0;
    if (r_last_sel == ErrSel) begin
      w_sel_rvalid = r_err_valid;
      mgr_rdata_o  = ErrRdata;
      mgr_err_o    = 1'b1;
      mgr_rid_o    = r_err_rid;
    end else begin
      for (int unsigned i = 0; i < NumRules; i++) begin
        if (r_last_sel == SelWidth'(i)) begin
          w_sel_rvalid = sbr_rvalid_i[i];
          mgr_rdata_o  = sbr_rdata_i[i*DataWidth +: DataWidth];
          mgr_err_o    = sbr_err_i[i];
          mgr_rid_o    = sbr_rid_i[i*IdWidth +: IdWidth];
        end
      end
    end
  end

  // A response with nothing outstanding is dropped so the counter cannot underflow.
  assign w_resp       = w_sel_rvalid && (r_cnt != '0);
  assign mgr_rvalid_o = w_resp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt       <= '0;
      r_last_sel  <= ErrSel;
      r_err_valid <= 1'b0;
      r_err_rid   <= '0;
    end else begin
      if (w_hs && !w_resp) begin
        r_cnt <= r_cnt + CntWidth'(1);
      end else if (!w_hs && w_resp) begin
        r_cnt <= r_cnt - CntWidth'(1);
      end
      if (w_hs) begin
        r_last_sel <= w_target;
      end
      r_err_valid <= w_hs & w_is_err;
      if (w_hs && w_is_err) begin
        r_err_rid <= mgr_aid_i;
      end
    end
  end

  assign busy_o     = (r_cnt != '0);
  // Pulses in the cycle the error subordinate returns its response.
  assign unmapped_o = r_err_valid;

  assign sbr_addr_o  = mgr_addr_i;
  assign sbr_we_o    = mgr_we_i;
  assign sbr_be_o    = mgr_be_i;
  assign sbr_wdata_o = mgr_wdata_i;
  assign sbr_aid_o   = mgr_aid_i;

  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_sel_rvalid && (r_cnt == '0)));

endmodule
